camellia_round_sched: RTL and testbench

Sequencer for the iterative Camellia core. It accepts one 128-bit block request, then steps the shared datapath through pre-whitening, the F-rounds, the FL/FL⁻¹ layers and post-whitening, one operation per clock. Each cycle it emits the subkey index, the FL-layer key index, the whitening-key select and the datapath operation code. It sits between the block-level valid/ready interface and the datapath registers (F stage, FL_Function, whitening XOR), and supports both encryption and decryption.

---
 rtl/camellia_round_sched_pkg.sv | 40 ++++
 rtl/camellia_round_sched_if.sv | 36 +++
 rtl/camellia_round_sched.sv | 143 ++++++++++++++
 tb/tb_camellia_round_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camellia_round_sched_pkg.sv
// camellia_round_sched_pkg
//   Shared types and helpers for the Camellia round sequencer:
//   controller state encoding, datapath operation codes, and
//   elaboration-time helpers for FL-layer count and block latency.
package camellia_round_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREW,
        S_RND,
        S_FL,
        S_POSTW,
        S_DONE
    } state_t;

    // POSTW reuses the whitening code; the datapath tells the two apart
    // through the separate post flag.
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_WHITEN  = 2'd1,
        OP_FROUND  = 2'd2,
        OP_FLLAYER = 2'd3
    } dp_op_t;

    localparam int unsigned K_IDX_W  = 5;
    localparam int unsigned FL_IDX_W = 2;

    // Number of FL/FL^-1 layers between round groups.
    function automatic int unsigned nfl_of(input int unsigned rounds,
                                           input int unsigned fl_every);
        return rounds / fl_every - 1;
    endfunction

    // Cycles from accept edge to out_valid.
    function automatic int unsigned latency_of(input int unsigned rounds,
                                               input int unsigned fl_every);
        return rounds + nfl_of(rounds, fl_every) + 3;
    endfunction

endpackage

// File: rtl/camellia_round_sched_if.sv
// camellia_round_sched_if
//   Block request/response handshake plus the per-cycle datapath
//   control bundle produced by the sequencer.
//   slave  : sequencer side (takes requests, drives datapath controls)
//   master : requester / datapath side
//   Signals: in_valid, in_ready, decrypt, key_ready, out_valid, out_ready,
//            dp_op[1:0], dp_en, k_idx[4:0], fl_idx[1:0], kw_sel, busy, post
interface camellia_round_sched_if;

    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       key_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] dp_op;
    logic       dp_en;
    logic [4:0] k_idx;
    logic [1:0] fl_idx;
    logic       kw_sel;
    logic       busy;
    logic       post;

    modport slave (
        input  in_valid, decrypt, key_ready, out_ready,
        output in_ready, out_valid, dp_op, dp_en, k_idx, fl_idx, kw_sel,
               busy, post
    );

    modport master (
        output in_valid, decrypt, key_ready, out_ready,
        input  in_ready, out_valid, dp_op, dp_en, k_idx, fl_idx, kw_sel,
               busy, post
    );

endinterface

// File: rtl/camellia_round_sched.sv
// camellia_round_sched
//   Sequencer for the iterative Camellia core. After accepting a block it
//   steps the shared datapath through pre-whitening, ROUNDS F-rounds with
//   an FL/FL^-1 layer after every FL_EVERY rounds (except the last group),
//   and post-whitening, one operation per clock, then holds the result
//   valid until the consumer takes it.
//   Ports:
//     clk  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - slave side of camellia_round_sched_if (handshake + dp controls)
//   Parameters:
//     ROUNDS   - number of F-rounds (multiple of FL_EVERY; 18 or 24)
//     FL_EVERY - F-rounds between FL layers
module camellia_round_sched
    import camellia_round_sched_pkg::*;
#(
    parameter int unsigned ROUNDS   = 18,
    parameter int unsigned FL_EVERY = 6
) (
    input  logic                    clk,
    input  logic                    RST,
    camellia_round_sched_if.slave   bus
);

    localparam int unsigned NFL = nfl_of(ROUNDS, FL_EVERY);

    state_t                state;
    state_t                state_nxt;
    logic [K_IDX_W-1:0]    r;
    logic [FL_IDX_W-1:0]   f;
    logic                  dec_q;
    logic                  in_ready_c;
    logic                  accept;
    logic                  last_round;
    logic                  fl_due;

    always_comb begin
        in_ready_c = bus.key_ready &
                     ((state == S_IDLE) | ((state == S_DONE) & bus.out_ready));
        accept     = bus.in_valid & in_ready_c;
    end

    // An FL layer is due once the round count reaches the next group
    // boundary (f+1)*FL_EVERY; the final group goes straight to POSTW.
    always_comb begin
        last_round = (r == K_IDX_W'(ROUNDS - 1));
        fl_due     = ((r + K_IDX_W'(1)) ==
                      (K_IDX_W'(f) + K_IDX_W'(1)) * K_IDX_W'(FL_EVERY)) &&
                     !last_round;
    end

    // State register
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round / FL-layer counters and latched mode
    always_ff @(posedge clk) begin
        if (RST) begin
            r     <= '0;
            f     <= '0;
            dec_q <= 1'b0;
        end else if (accept) begin
            r     <= '0;
            f     <= '0;
            dec_q <= bus.decrypt;
        end else begin
            if (state == S_RND) begin
                r <= r + K_IDX_W'(1);
            end
            if (state == S_FL) begin
                f <= f + FL_IDX_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_PREW;
            S_PREW:  state_nxt = S_RND;
            S_RND: begin
                if (last_round) begin
                    state_nxt = S_POSTW;
                end else if (fl_due) begin
                    state_nxt = S_FL;
                end
            end
            S_FL:    state_nxt = S_RND;
            S_POSTW: state_nxt = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_nxt = S_PREW;
                end else if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = (state == S_DONE);
        bus.busy      = (state != S_IDLE) && (state != S_DONE);
        bus.post      = (state == S_POSTW);
        bus.dp_op     = OP_NOP;
        bus.dp_en     = 1'b0;
        bus.k_idx     = '0;
        bus.fl_idx    = '0;
        bus.kw_sel    = 1'b0;
        unique case (state)
            S_PREW: begin
                bus.dp_op  = OP_WHITEN;
                bus.dp_en  = 1'b1;
                bus.kw_sel = dec_q;
            end
            S_RND: begin
                bus.dp_op = OP_FROUND;
                bus.dp_en = 1'b1;
                bus.k_idx = dec_q ? (K_IDX_W'(ROUNDS - 1) - r) : r;
            end
            S_FL: begin
                bus.dp_op  = OP_FLLAYER;
                bus.dp_en  = 1'b1;
                bus.fl_idx = dec_q ? (FL_IDX_W'(NFL - 1) - f) : f;
            end
            S_POSTW: begin
                bus.dp_op  = OP_WHITEN;
                bus.dp_en  = 1'b1;
                bus.kw_sel = ~dec_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_camellia_round_sched.sv
// tb_camellia_round_sched
//   Self-checking bench for camellia_round_sched. A cycle-level reference
//   model keeps a queue of expected datapath operations per block; every
//   output is compared each cycle on the falling edge. A vector table
//   drives encrypt/decrypt blocks with key_ready delay, backpressure and
//   back-to-back requests; hand-written sequences cover mid-block reset
//   and a 24-round instance.
module tb_camellia_round_sched;

    logic clk;
    logic RST;

    camellia_round_sched_if if18 ();
    camellia_round_sched_if if24 ();

    camellia_round_sched #(.ROUNDS(18), .FL_EVERY(6)) dut18 (
        .clk (clk),
        .RST (RST),
        .bus (if18.slave)
    );

    camellia_round_sched #(.ROUNDS(24), .FL_EVERY(6)) dut24 (
        .clk (clk),
        .RST (RST),
        .bus (if24.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] k;
        logic [1:0] fl;
        logic       kw;
        logic       post;
    } exp_t;

    exp_t sb[$];
    bit   m_done = 1'b0;
    bit   mon_on = 1'b0;

    // Expected operation stream for one 18-round block.
    task automatic push_trace(input bit dec);
        int unsigned layer;
        layer = 0;
        sb.push_back('{op: 2'd1, k: 5'd0, fl: 2'd0, kw: dec, post: 1'b0});
        for (int unsigned i = 0; i < 18; i++) begin
            sb.push_back('{op: 2'd2, k: dec ? 5'(17 - i) : 5'(i), fl: 2'd0,
                           kw: 1'b0, post: 1'b0});
            if (((i + 1) % 6 == 0) && (i + 1 < 18)) begin
                sb.push_back('{op: 2'd3, k: 5'd0,
                               fl: dec ? 2'(1 - layer) : 2'(layer),
                               kw: 1'b0, post: 1'b0});
                layer++;
            end
        end
        sb.push_back('{op: 2'd1, k: 5'd0, fl: 2'd0, kw: ~dec, post: 1'b1});
    endtask

    task automatic chk(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Per-cycle monitor and reference model for the 18-round instance.
    // Fields: {in_ready,out_valid,busy,dp_en,dp_op,k_idx,fl_idx,kw_sel,post}
    always @(negedge clk) begin : mon
        logic [14:0] act_v;
        logic [14:0] exp_v;
        logic        exp_rdy;
        logic        acc;
        exp_t        e;
        if (mon_on) begin
            act_v = {if18.in_ready, if18.out_valid, if18.busy, if18.dp_en,
                     if18.dp_op, if18.k_idx, if18.fl_idx, if18.kw_sel, if18.post};
            if (sb.size() > 0) begin
                e       = sb[0];
                exp_rdy = 1'b0;
                exp_v   = {1'b0, 1'b0, 1'b1, 1'b1, e};
            end else if (m_done) begin
                exp_rdy = if18.key_ready & if18.out_ready;
                exp_v   = {exp_rdy, 1'b1, 13'b0};
            end else begin
                exp_rdy = if18.key_ready;
                exp_v   = {exp_rdy, 1'b0, 13'b0};
            end
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %b, want %b", cyc, act_v, exp_v);
            end
            acc = if18.in_valid & exp_rdy;
            if (RST) begin
                sb.delete();
                m_done = 1'b0;
            end else if (sb.size() > 0) begin
                void'(sb.pop_front());
                if (sb.size() == 0) m_done = 1'b1;
            end else if (acc) begin
                push_trace(if18.decrypt);
                m_done = 1'b0;
            end else if (m_done && if18.out_ready) begin
                m_done = 1'b0;
            end
        end
    end

    typedef struct {
        bit          dec;
        int unsigned kr_delay;  // cycles with key_ready low before raising it
        int unsigned bp;        // extra DONE cycles with out_ready low
        bit          b2b;       // request issued while previous block in DONE
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int unsigned lat;
        int unsigned prev_ov;
        int unsigned kexp;
        int unsigned flexp;
        int unsigned kbad;
        bit          release_now;

        RST = 1'b1;
        if18.in_valid = 0; if18.decrypt = 0; if18.key_ready = 0; if18.out_ready = 0;
        if24.in_valid = 0; if24.decrypt = 0; if24.key_ready = 0; if24.out_ready = 0;
        prev_ov = 0;

        vecs[0] = '{dec: 1'b0, kr_delay: 0, bp: 0, b2b: 1'b0, exp_lat: 23};
        vecs[1] = '{dec: 1'b1, kr_delay: 3, bp: 5, b2b: 1'b0, exp_lat: 23};
        vecs[2] = '{dec: 1'b0, kr_delay: 0, bp: 0, b2b: 1'b1, exp_lat: 23};
        vecs[3] = '{dec: 1'b1, kr_delay: 0, bp: 2, b2b: 1'b1, exp_lat: 23};

        step();
        mon_on = 1'b1;
        step();
        RST = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            if18.in_valid = 1'b1;
            if18.decrypt  = vecs[i].dec;
            if (vecs[i].b2b) begin
                if18.key_ready = 1'b1;
                if18.out_ready = 1'b1;
            end else begin
                if18.key_ready = 1'b0;
                for (int unsigned d = 0; d < vecs[i].kr_delay; d++) step();
                if18.key_ready = 1'b1;
            end
            step();
            if18.out_ready = 1'b0;
            lat = 1;
            while (!if18.out_valid && lat < 100) begin
                if18.in_valid  = 1'($urandom_range(0, 1));
                if18.key_ready = 1'($urandom_range(0, 1));
                if18.decrypt   = 1'($urandom_range(0, 1));
                step();
                lat++;
            end
            if18.in_valid  = 1'b0;
            if18.key_ready = 1'b1;
            chk($sformatf("latency v%0d", i), int'(lat), int'(vecs[i].exp_lat));
            if (vecs[i].b2b && i > 0) begin
                if (vecs[i-1].bp == 0) begin
                    chk($sformatf("b2b spacing v%0d", i), int'(cyc - prev_ov), 23);
                end
            end
            prev_ov = cyc;
            for (int unsigned b = 0; b < vecs[i].bp; b++) step();
            release_now = 1'b1;
            if (i < 3) begin
                if (vecs[i+1].b2b) release_now = 1'b0;
            end
            if (release_now) begin
                if18.out_ready = 1'b1;
                step();
                if18.out_ready = 1'b0;
                step();
            end
        end

        // Mid-block reset: accept, run to block cycle 10, reset.
        if18.in_valid = 1'b1; if18.decrypt = 1'b0; if18.key_ready = 1'b1;
        step();
        if18.in_valid = 1'b0;
        repeat (9) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("reset out_valid", int'(if18.out_valid), 0);
        chk("reset busy/dp_en/dp_op",
            int'({if18.busy, if18.dp_en, if18.dp_op}), 0);
        chk("reset k/fl/kw", int'({if18.k_idx, if18.fl_idx, if18.kw_sel}), 0);
        chk("reset in_ready", int'(if18.in_ready), 1);
        repeat (3) step();

        // 24-round encrypt block.
        if24.in_valid = 1'b1; if24.key_ready = 1'b1; if24.decrypt = 1'b0;
        step();
        if24.in_valid = 1'b0;
        lat = 1; kexp = 0; flexp = 0; kbad = 0;
        while (!if24.out_valid && lat < 100) begin
            if (if24.dp_op == 2'd2) begin
                if (if24.k_idx != 5'(kexp)) kbad++;
                kexp++;
            end else if (if24.dp_op == 2'd3) begin
                if (if24.fl_idx != 2'(flexp)) kbad++;
                flexp++;
            end
            step();
            lat++;
        end
        chk("r24 latency", int'(lat), 30);
        chk("r24 FL layers", int'(flexp), 3);
        chk("r24 F-rounds", int'(kexp), 24);
        chk("r24 index errors", int'(kbad), 0);
        if24.out_ready = 1'b1;
        step();
        if24.out_ready = 1'b0;
        chk("r24 release", int'(if24.out_valid), 0);

        mon_on = 1'b0;
        chk("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
